// File: rtl/aes_dec_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the iterative
// AES-128 inverse cipher.
package aes_dec_pkg;

   localparam int NR       = 10;
   localparam int RK_IDX_W = 4;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by x modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (only 9, 11, 13, 14 are used)
   function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   // InvMixColumns on one column; byte 0 of the column is bits [31:24]
   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul_const(a0, 4'd14) ^ gf_mul_const(a1, 4'd11) ^ gf_mul_const(a2, 4'd13) ^ gf_mul_const(a3, 4'd9),
              gf_mul_const(a0, 4'd9)  ^ gf_mul_const(a1, 4'd14) ^ gf_mul_const(a2, 4'd11) ^ gf_mul_const(a3, 4'd13),
              gf_mul_const(a0, 4'd13) ^ gf_mul_const(a1, 4'd9)  ^ gf_mul_const(a2, 4'd14) ^ gf_mul_const(a3, 4'd11),
              gf_mul_const(a0, 4'd11) ^ gf_mul_const(a1, 4'd13) ^ gf_mul_const(a2, 4'd9)  ^ gf_mul_const(a3, 4'd14)};
   endfunction

endpackage

// File: rtl/decrypt_round_comb.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when final_round).
// Byte i of a block is bits [127-8i -: 8]; state[r][c] is byte r+4c.
module decrypt_round_comb
   import aes_dec_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] state_out
);

   logic [127:0] shifted, subbed, keyed, mixed;

   // Full inverse round datapath
   always_comb begin
      shifted = '0;
      subbed  = '0;
      mixed   = '0;
      // Row r rotates right by r: out[r][c] = in[r][(c-r) mod 4]
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            shifted[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
         end
      end
      for (int unsigned i = 0; i < 16; i++) begin
         subbed[127 - 8*i -: 8] = INV_SBOX[shifted[127 - 8*i -: 8]];
      end
      keyed = subbed ^ round_key;
      for (int unsigned c = 0; c < 4; c++) begin
         mixed[127 - 32*c -: 32] = inv_mix_column(keyed[127 - 32*c -: 32]);
      end
      state_out = final_round ? keyed : mixed;
   end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// fetched from an external combinational store via rk_idx/rk_data.
// Optional abort input enabled by defining AES_DEC_ABORT_EN.
module aes128_decrypt_iter
   import aes_dec_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
`ifdef AES_DEC_ABORT_EN
   input  logic                abort,
`endif
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        ciphertext,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        plaintext,
   output logic                busy
);

   state_t       fsm_state;
   logic [3:0]   round_cnt;
   logic [127:0] state_reg;
   logic [127:0] round_out;
   logic         abort_i;

`ifdef AES_DEC_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   decrypt_round_comb u_round (
      .state_in    (state_reg),
      .round_key   (rk_data),
      .final_round (round_cnt == 4'd0),
      .state_out   (round_out)
   );

   // Control FSM and data registers; rk_idx is registered so the key store
   // sees a glitch-free index that tracks the round counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_state <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         plaintext <= '0;
         state_reg <= '0;
         round_cnt <= 4'(NR - 1);
         rk_idx    <= RK_IDX_W'(NR);
      end else if (abort_i && (fsm_state != IDLE)) begin
         fsm_state <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         plaintext <= '0;
         round_cnt <= 4'(NR - 1);
         rk_idx    <= RK_IDX_W'(NR);
      end else begin
         unique case (fsm_state)
            IDLE: begin
               if (in_valid && !abort_i) begin
                  state_reg <= ciphertext ^ rk_data;
                  round_cnt <= 4'(NR - 1);
                  rk_idx    <= RK_IDX_W'(NR - 1);
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  fsm_state <= ROUND;
               end
            end
            ROUND: begin
               if (round_cnt == 4'd0) begin
                  plaintext <= round_out;
                  out_valid <= 1'b1;
                  rk_idx    <= RK_IDX_W'(NR);
                  fsm_state <= DONE;
               end else begin
                  state_reg <= round_out;
                  round_cnt <= round_cnt - 4'd1;
                  rk_idx    <= RK_IDX_W'(round_cnt - 4'd1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  fsm_state <= IDLE;
               end
            end
            default: fsm_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench for aes128_decrypt_iter: known-answer vectors, latency,
// back-pressure, back-to-back, asynchronous reset and (with AES_DEC_ABORT_EN) abort.
module tb_aes128_decrypt_iter;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, out_valid, out_ready, busy, abort;
   logic [127:0] ciphertext, rk_data, plaintext, exp_pt;
   logic [3:0]   rk_idx;

   logic [7:0]   fsbox [256];
   logic [127:0] rk_tab [16];
   logic [127:0] sb_q [$];
   vec_t         vecs [4];

   int   checks = 0, errors = 0, cyc = 0, n_pop = 0, exp_outputs = 0;
   int   last_acc = 0, prev_acc = 0;
   logic prev_ov = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

   aes128_decrypt_iter dut (
      .clk        (clk),
      .reset      (reset),
`ifdef AES_DEC_ABORT_EN
      .abort      (abort),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .rk_idx     (rk_idx),
      .rk_data    (rk_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = '0; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {fsbox[t[31:24]], fsbox[t[23:16]], fsbox[t[15:8]], fsbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 11; r < 16; r++) rk_tab[r] = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_accept(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      if (!ok) begin checks++; errors++; $display("FAIL %s: no accept in 40 cycles", name); end
      step();
   endtask

   task automatic wait_out(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1;
      end
      if (!ok) begin checks++; errors++; $display("FAIL %s: no out_valid in 40 cycles", name); end
      step();
   endtask

   task automatic wait_idx(input logic [3:0] v, input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rk_idx == v) ok = 1;
      end
      if (!ok) begin checks++; errors++; $display("FAIL %s: rk_idx never reached %0d", name, v); end
   endtask

   task automatic send(input vec_t v, input string name);
      expand(v.key);
      ciphertext = v.ct;
      exp_pt     = v.pt;
      in_valid   = 1'b1;
      wait_accept(name);
      in_valid   = 1'b0;
      wait_out(name);
      exp_outputs++;
   endtask

   // Scoreboard monitor: pushes expectations on accept, pops on output transfer
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
         prev_ov = 1'b0;
      end else begin
         chk("rk_idx_range", 128'(rk_idx <= 4'd10), 128'd1);
         if (out_valid && !prev_ov) chk("latency", 128'(cyc - last_acc), 128'd10);
         prev_ov = out_valid;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got %h expected none", plaintext);
            end else begin
               chk("plaintext", plaintext, sb_q.pop_front());
               n_pop++;
            end
         end
         if (abort && busy) sb_q.delete();
         if (in_valid && in_ready && !abort) begin
            sb_q.push_back(exp_pt);
            prev_acc = last_acc;
            last_acc = cyc + 1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] inv, b;
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a};

      // Forward S-box from GF inverse plus affine map, used only by the key store
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         fsbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      expand(vecs[0].key);
      if (rk_tab[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
         $display("FAIL key_store_model: rk10 %h", rk_tab[10]);
         $fatal(1);
      end

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
      ciphertext = '0; exp_pt = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_plaintext", plaintext, 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd10);
      step();
      reset = 1'b0;
      step();

      // Known-answer with rk_idx trace, then 20 cycles of back-pressure
      out_ready  = 1'b0;
      ciphertext = vecs[0].ct;
      exp_pt     = vecs[0].pt;
      in_valid   = 1'b1;
      @(negedge clk);
      chk("idle_rk_idx", 128'(rk_idx), 128'd10);
      chk("idle_in_ready", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
      exp_outputs++;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("rk_idx_seq", 128'(rk_idx), 128'(9 - k));
         chk("round_busy", 128'(busy), 128'd1);
         chk("round_out_valid", 128'(out_valid), 128'd0);
      end
      @(negedge clk);
      chk("out_valid_rise", 128'(out_valid), 128'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_plaintext", plaintext, vecs[0].pt);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         step();
         in_valid   = ~in_valid;
         ciphertext = {$urandom, $urandom, $urandom, $urandom};
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_in_ready", 128'(in_ready), 128'd1);
      chk("release_out_valid", 128'(out_valid), 128'd0);
      chk("release_plaintext_held", plaintext, vecs[0].pt);
      #1;

      // Vector table
      for (int v = 0; v < 4; v++) send(vecs[v], "table");

      // Back-to-back accepts with in_valid held high
      expand(vecs[2].key);
      ciphertext = vecs[2].ct;
      exp_pt     = vecs[2].pt;
      in_valid   = 1'b1;
      wait_accept("b2b_first");
      ciphertext = vecs[3].ct;
      exp_pt     = vecs[3].pt;
      wait_accept("b2b_second");
      in_valid = 1'b0;
      chk("b2b_interval", 128'(last_acc - prev_acc), 128'd12);
      wait_out("b2b_out");
      exp_outputs += 2;

      // Asynchronous reset at round counter 5
      expand(vecs[0].key);
      ciphertext = vecs[0].ct;
      exp_pt     = vecs[0].pt;
      in_valid   = 1'b1;
      wait_accept("rst_mid_accept");
      in_valid = 1'b0;
      wait_idx(4'd5, "rst_mid_wait");
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
      chk("rst_mid_plaintext", plaintext, 128'd0);
      chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
      chk("rst_mid_rk_idx", 128'(rk_idx), 128'd10);
      step(); step();
      reset = 1'b0;
      step();
      send(vecs[0], "after_reset");

`ifdef AES_DEC_ABORT_EN
      // Abort at round counter 3, then abort racing in_valid in IDLE
      ciphertext = vecs[0].ct;
      exp_pt     = vecs[0].pt;
      in_valid   = 1'b1;
      wait_accept("abort_accept");
      in_valid = 1'b0;
      wait_idx(4'd4, "abort_wait");
      step();
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_plaintext", plaintext, 128'd0);
      chk("abort_rk_idx", 128'(rk_idx), 128'd10);
      #1 abort = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_out", 128'(out_valid), 128'd0);
      end
      step();
      abort    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_idle_busy", 128'(busy), 128'd0);
      chk("abort_idle_in_ready", 128'(in_ready), 128'd1);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      step();
      send(vecs[0], "after_abort");
`endif

      step();
      chk("sb_empty", 128'(sb_q.size()), 128'd0);
      chk("outputs", 128'(n_pop), 128'(exp_outputs));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
